// File: rtl/commit_trace_fifo.sv
// Commit-trace producer: buffers one record per retired instruction in a FWFT FIFO
// and flags end of program. Define TRACE_REGWRITE_ONLY_EN to trace only register-writing commits.
module commit_trace_fifo #(
  parameter int unsigned DEPTH       = 16,
  parameter logic [31:0] HALT_PC     = 32'h0000_0400,
  parameter int unsigned CYCLE_LIMIT = 1000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_inst,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_wdata,
  output logic        tr_valid,
  input  logic        tr_ready,
  output logic [31:0] tr_pc,
  output logic [31:0] tr_inst,
  output logic [4:0]  tr_rd,
  output logic [31:0] tr_wdata,
  output logic        tr_we,
  output logic        stall_req,
  output logic        halted,
  output logic [1:0]  halt_cause,
  output logic        done,
  output logic [15:0] drop_cnt,
  output logic [31:0] cycle_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned RW = 102;
  localparam logic [AW:0] FULL_OCC  = DEPTH[AW:0];
  localparam logic [AW:0] STALL_OCC = FULL_OCC - {{AW{1'b0}}, 1'b1};
  localparam logic [31:0] LIMIT_M1  = CYCLE_LIMIT - 32'd1;

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

  state_t          state_r, state_nxt_s;
  logic [1:0]      halt_cause_r, halt_cause_nxt_s;
  logic [RW-1:0]   mem_r [DEPTH];
  logic [RW-1:0]   rec_s, head_s;
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [AW:0]     occ_r;
  logic [15:0]     drop_cnt_r;
  logic [31:0]     cycle_cnt_r;
  logic            run_s, full_s, empty_s, accept_s;
  logic            push_s, pop_s, drop_s, halt_pc_s, limit_s;

  assign run_s   = (state_r == ST_RUN);
  assign full_s  = (occ_r == FULL_OCC);
  assign empty_s = (occ_r == {(AW+1){1'b0}});
  assign pop_s   = !empty_s && tr_ready;

`ifdef TRACE_REGWRITE_ONLY_EN
  assign accept_s  = wb_valid && wb_regwrite && (wb_rd != 5'd0);
  // A filtered halt instruction still ends the run even though it is not recorded.
  assign halt_pc_s = run_s && wb_valid && (wb_pc == HALT_PC);
`else
  assign accept_s  = wb_valid;
  assign halt_pc_s = push_s && (wb_pc == HALT_PC);
`endif

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_s  = run_s && accept_s && (!full_s || pop_s);
  assign drop_s  = run_s && accept_s && full_s && !pop_s;
  assign limit_s = run_s && (cycle_cnt_r == LIMIT_M1);

  assign rec_s  = {wb_pc, wb_inst, wb_rd, wb_wdata, wb_regwrite && (wb_rd != 5'd0)};
  assign head_s = mem_r[rd_ptr_r];

  // Next-state and halt-cause selection; halt PC has priority over the cycle limit.
  always_comb begin
    state_nxt_s      = state_r;
    halt_cause_nxt_s = halt_cause_r;
    case (state_r)
      ST_RUN: begin
        if (halt_pc_s) begin
          state_nxt_s      = ST_HALTED;
          halt_cause_nxt_s = 2'b01;
        end else if (limit_s) begin
          state_nxt_s      = ST_HALTED;
          halt_cause_nxt_s = 2'b10;
        end else begin
          state_nxt_s      = ST_RUN;
        end
      end
      ST_HALTED: state_nxt_s = ST_HALTED;
      default:   state_nxt_s = ST_RUN;
    endcase
  end

  // State, pointers, occupancy and counters.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r      <= ST_RUN;
      halt_cause_r <= 2'b00;
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      occ_r        <= {(AW+1){1'b0}};
      drop_cnt_r   <= 16'd0;
      cycle_cnt_r  <= 32'd0;
    end else begin
      state_r      <= state_nxt_s;
      halt_cause_r <= halt_cause_nxt_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      if (pop_s)  rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + {{AW{1'b0}}, 1'b1};
        2'b01:   occ_r <= occ_r - {{AW{1'b0}}, 1'b1};
        default: occ_r <= occ_r;
      endcase
      if (drop_s && (drop_cnt_r != 16'hFFFF)) drop_cnt_r <= drop_cnt_r + 16'd1;
      if (run_s) cycle_cnt_r <= cycle_cnt_r + 32'd1;
    end
  end

  // Record storage; contents are only observed through the valid-gated head.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= rec_s;
  end

  // Head record presentation, zeroed while the FIFO is empty.
  always_comb begin
    tr_pc    = 32'd0;
    tr_inst  = 32'd0;
    tr_rd    = 5'd0;
    tr_wdata = 32'd0;
    tr_we    = 1'b0;
    if (!empty_s) begin
      {tr_pc, tr_inst, tr_rd, tr_wdata, tr_we} = head_s;
    end else begin
      tr_we = 1'b0;
    end
  end

  assign tr_valid   = !empty_s;
  assign stall_req  = (occ_r >= STALL_OCC);
  assign halted     = (state_r == ST_HALTED);
  assign halt_cause = halt_cause_r;
  assign done       = halted && empty_s;
  assign drop_cnt   = drop_cnt_r;
  assign cycle_cnt  = cycle_cnt_r;

endmodule
